// File: rtl/aes_inv_mixcolumns_seq.sv
// Iterative AES InvMixColumns: captures a 128-bit state, transforms COLS_PER_CYCLE
// columns per BUSY cycle, then holds the result on a valid/ready output handshake.
module aes_inv_mixcolumns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
    $error("aes_inv_mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q;
  logic [127:0]  src_q;
  logic [127:0]  out_q;
  logic [127:0]  out_next;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One InvMixColumns column; the odd constants are composed from xtime chains.
  function automatic logic [31:0] inv_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    logic [7:0] r0, r1, r2, r3;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[8*i +: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    r0 = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    r1 = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    r2 = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    r3 = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    return {r3, r2, r1, r0};
  endfunction

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    out_next = out_q;
    for (int c = 0; c < COLS_PER_CYCLE; c++) begin
      logic [1:0] sel;
      sel = idx_q + 2'(c);
      out_next[{sel, 5'b0} +: 32] = inv_col(src_q[{sel, 5'b0} +: 32]);
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (idx_q == LAST_IDX) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_state = out_q;

  // NOTE: non-blocking assignments for all registered state, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && in_valid) begin
        idx_q <= '0;
      end else if (state_q == S_BUSY) begin
        idx_q <= idx_q + STEP;
        out_q <= out_next;
      end
    end
  end

  // NOTE: the capture register is left out of reset; it is always loaded before it is read.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && in_valid) src_q <= in_state;
  end

endmodule
